// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: round-robin arbiter that lets two requesters share one data memory.
// Ports: Clk, Reset_n (async, active-low); per requester Req/We/Addr/WData in and
// Ack/Err out; RData is the shared read-data return, valid with Ack; Busy while a
// transaction is in flight; MemAddr/MemWData/MemWrite/MemRead drive the memory and
// MemRData is its combinational read data.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 32
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Req0,
    input  logic                  Req1,
    input  logic                  We0,
    input  logic                  We1,
    input  logic [ADDR_WIDTH-1:0] Addr0,
    input  logic [ADDR_WIDTH-1:0] Addr1,
    input  logic [DATA_WIDTH-1:0] WData0,
    input  logic [DATA_WIDTH-1:0] WData1,
    output logic                  Ack0,
    output logic                  Ack1,
    output logic                  Err0,
    output logic                  Err1,
    output logic [DATA_WIDTH-1:0] RData,
    output logic                  Busy,
    output logic [ADDR_WIDTH-1:0] MemAddr,
    output logic [DATA_WIDTH-1:0] MemWData,
    output logic                  MemWrite,
    output logic                  MemRead,
    input  logic [DATA_WIDTH-1:0] MemRData
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    state_t state;
    logic last, owner, we, err;
    logic grant1, gnt_we, gnt_err;
    logic [ADDR_WIDTH-1:0] gnt_addr;
    logic [DATA_WIDTH-1:0] gnt_wdata;
    // port 1 wins when alone, or on a tie when port 0 was granted last
    assign grant1    = Req1 & (~Req0 | ~last);
    assign gnt_we    = grant1 ? We1 : We0;
    assign gnt_addr  = grant1 ? Addr1 : Addr0;
    assign gnt_wdata = grant1 ? WData1 : WData0;
    assign gnt_err   = {1'b0, gnt_addr} >= (ADDR_WIDTH + 1)'(DEPTH);
    assign Busy      = state != IDLE;
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            owner    <= 1'b0;
            we       <= 1'b0;
            err      <= 1'b0;
            MemAddr  <= '0;
            MemWData <= '0;
            MemWrite <= 1'b0;
            MemRead  <= 1'b0;
            RData    <= '0;
            Ack0     <= 1'b0;
            Ack1     <= 1'b0;
            Err0     <= 1'b0;
            Err1     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (Req0 | Req1) begin
                    state    <= ACCESS;
                    last     <= grant1;
                    owner    <= grant1;
                    we       <= gnt_we;
                    err      <= gnt_err;
                    MemAddr  <= gnt_addr;
                    MemWData <= gnt_wdata;
                    // out-of-range accesses never touch the memory
                    MemWrite <= gnt_we & ~gnt_err;
                    MemRead  <= ~gnt_we & ~gnt_err;
                end
                ACCESS: begin
                    state    <= DONE;
                    MemWrite <= 1'b0;
                    MemRead  <= 1'b0;
                    RData    <= (!we && !err) ? MemRData : '0;
                    Ack0     <= ~owner;
                    Ack1     <= owner;
                    Err0     <= ~owner & err;
                    Err1     <= owner & err;
                end
                default: begin
                    state <= IDLE;
                    RData <= '0;
                    Ack0  <= 1'b0;
                    Ack1  <= 1'b0;
                    Err0  <= 1'b0;
                    Err1  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: directed self-checking bench for data_mem_arbiter.
module tb_data_mem_arbiter;
    localparam int DW = 32, AW = 32, DEPTH = 32;
    logic Clk = 1'b0, Reset_n = 1'b1;
    logic Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
    logic [AW-1:0] Addr0 = '0, Addr1 = '0;
    logic [DW-1:0] WData0 = '0, WData1 = '0;
    logic Ack0, Ack1, Err0, Err1, Busy, MemWrite, MemRead;
    logic [DW-1:0] RData, MemWData, MemRData;
    logic [AW-1:0] MemAddr;
    logic [DW-1:0] mem [DEPTH];
    int wr_count = 0, rd_count = 0, both_count = 0;
    int n_vec = 0, n_fail = 0;

    data_mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
        .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
        .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
        .RData(RData), .Busy(Busy),
        .MemAddr(MemAddr), .MemWData(MemWData), .MemWrite(MemWrite), .MemRead(MemRead),
        .MemRData(MemRData)
    );

    always #5 Clk = ~Clk;

    // memory out of range returns a poison value so a leaked read is visible
    assign MemRData = (MemAddr < AW'(DEPTH)) ? mem[MemAddr[4:0]] : 32'hBAD0_0000;

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'hA000_0000 + i;
        forever begin
            @(posedge Clk);
            if (MemWrite && MemRead) both_count++;
            if (MemRead) rd_count++;
            if (MemWrite) begin
                wr_count++;
                mem[MemAddr[4:0]] = MemWData;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic apply_reset();
        Reset_n = 1'b0;
        cyc();
        cyc();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #2 Reset_n = 1'b0;
        #1;
        n_vec++;
        if ({Busy, Ack0, Ack1, Err0, Err1, MemWrite, MemRead} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000", {Busy, Ack0, Ack1, Err0, Err1, MemWrite, MemRead});
        end
        n_vec++;
        if ({RData, MemAddr, MemWData} !== 96'b0) begin
            n_fail++;
            $display("FAIL reset_buses: got RData=%h MemAddr=%h MemWData=%h want 0", RData, MemAddr, MemWData);
        end
        Req0 = 1'b1;
        cyc();
        cyc();
        n_vec++;
        if (Busy !== 1'b0 || MemRead !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: got Busy=%b MemRead=%b want 0 0", Busy, MemRead);
        end
        Req0 = 1'b0;
        Reset_n = 1'b1;
    endtask

    task automatic test_write_read();
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 5; WData0 = 32'hDEAD_BEEF;
        cyc();
        n_vec++;
        if ({MemWrite, MemRead, Busy, Ack0} !== 4'b1010) begin
            n_fail++;
            $display("FAIL wr_access: got MemWrite,MemRead,Busy,Ack0=%b want 1010", {MemWrite, MemRead, Busy, Ack0});
        end
        n_vec++;
        if (MemAddr !== 32'd5 || MemWData !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL wr_bus: got MemAddr=%h MemWData=%h want 5 deadbeef", MemAddr, MemWData);
        end
        cyc();
        n_vec++;
        if ({Ack0, Ack1, Err0, MemWrite} !== 4'b1000) begin
            n_fail++;
            $display("FAIL wr_ack: got Ack0,Ack1,Err0,MemWrite=%b want 1000", {Ack0, Ack1, Err0, MemWrite});
        end
        n_vec++;
        if (mem[5] !== 32'hDEAD_BEEF || RData !== 32'h0) begin
            n_fail++;
            $display("FAIL wr_mem: got mem5=%h RData=%h want deadbeef 0", mem[5], RData);
        end
        Req0 = 1'b0;
        cyc();
        n_vec++;
        if ({Ack0, Busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_idle: got Ack0,Busy=%b want 00", {Ack0, Busy});
        end
        Req0 = 1'b1; We0 = 1'b0;
        cyc();
        n_vec++;
        if ({MemRead, MemWrite, Ack0} !== 3'b100) begin
            n_fail++;
            $display("FAIL rd_access: got MemRead,MemWrite,Ack0=%b want 100", {MemRead, MemWrite, Ack0});
        end
        cyc();
        n_vec++;
        if (Ack0 !== 1'b1 || Err0 !== 1'b0 || RData !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL rd_ack: got Ack0=%b Err0=%b RData=%h want 1 0 deadbeef", Ack0, Err0, RData);
        end
        Req0 = 1'b0;
        cyc();
    endtask

    task automatic test_round_robin();
        logic [1:0] exp;
        apply_reset();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 1;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 2;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            exp = {i == 5 || i == 11, i == 2 || i == 8};
            n_vec++;
            if ({Ack1, Ack0} !== exp) begin
                n_fail++;
                $display("FAIL rr_ack cycle %0d: got Ack1,Ack0=%b want %b", i, {Ack1, Ack0}, exp);
            end
            if (exp != 2'b00) begin
                n_vec++;
                if (RData !== (exp[0] ? 32'hA000_0001 : 32'hA000_0002)) begin
                    n_fail++;
                    $display("FAIL rr_rdata cycle %0d: got %h want %h", i, RData, exp[0] ? 32'hA000_0001 : 32'hA000_0002);
                end
            end
        end
        Req0 = 1'b0; Req1 = 1'b0;
        cyc();
    endtask

    task automatic test_out_of_range();
        int rc;
        rc = rd_count;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 32;
        cyc();
        n_vec++;
        if ({MemRead, MemWrite, Busy} !== 3'b001 || MemAddr !== 32'd32) begin
            n_fail++;
            $display("FAIL oor_access: got MemRead,MemWrite,Busy=%b MemAddr=%h want 001 20", {MemRead, MemWrite, Busy}, MemAddr);
        end
        cyc();
        n_vec++;
        if ({Ack1, Err1, Ack0, Err0} !== 4'b1100 || RData !== 32'h0) begin
            n_fail++;
            $display("FAIL oor_ack: got Ack1,Err1,Ack0,Err0=%b RData=%h want 1100 0", {Ack1, Err1, Ack0, Err0}, RData);
        end
        Req1 = 1'b0;
        cyc();
        n_vec++;
        if ({Ack1, Err1} !== 2'b00 || rd_count !== rc) begin
            n_fail++;
            $display("FAIL oor_after: got Ack1,Err1=%b reads=%0d want 00 %0d", {Ack1, Err1}, rd_count, rc);
        end
    endtask

    task automatic test_latch();
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 7; WData0 = 32'h1234_5678;
        cyc();
        Addr0 = 9; WData0 = 32'hFFFF_FFFF; We0 = 1'b0;
        #1;
        n_vec++;
        if (MemAddr !== 32'd7 || MemWData !== 32'h1234_5678 || MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL latch_bus: got MemAddr=%h MemWData=%h MemWrite=%b want 7 12345678 1", MemAddr, MemWData, MemWrite);
        end
        cyc();
        n_vec++;
        if (Ack0 !== 1'b1 || mem[7] !== 32'h1234_5678 || mem[9] !== 32'hA000_0009) begin
            n_fail++;
            $display("FAIL latch_mem: got Ack0=%b mem7=%h mem9=%h want 1 12345678 a0000009", Ack0, mem[7], mem[9]);
        end
        Req0 = 1'b0;
        cyc();
    endtask

    task automatic test_reset_abort();
        int wc;
        wc = wr_count;
        Req0 = 1'b1; We0 = 1'b1; Addr0 = 3; WData0 = 32'h1;
        cyc();
        n_vec++;
        if (MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: got MemWrite=%b want 1", MemWrite);
        end
        #1 Reset_n = 1'b0;
        #1;
        n_vec++;
        if ({MemWrite, Busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_now: got MemWrite,Busy=%b want 00", {MemWrite, Busy});
        end
        Req0 = 1'b0;
        #2 Reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (Ack0 !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_noack cycle %0d: got Ack0=%b want 0", i, Ack0);
            end
        end
        n_vec++;
        if (wr_count !== wc || mem[3] !== 32'hA000_0003) begin
            n_fail++;
            $display("FAIL abort_mem: got writes=%0d mem3=%h want %0d a0000003", wr_count, mem[3], wc);
        end
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 3;
        cyc();
        cyc();
        n_vec++;
        if (Ack0 !== 1'b1 || RData !== 32'hA000_0003) begin
            n_fail++;
            $display("FAIL abort_read: got Ack0=%b RData=%h want 1 a0000003", Ack0, RData);
        end
        Req0 = 1'b0;
        cyc();
    endtask

    task automatic test_withdraw();
        Req0 = 1'b1; We0 = 1'b0; Addr0 = 4;
        cyc();
        Req0 = 1'b0;
        Req1 = 1'b1; We1 = 1'b0; Addr1 = 6;
        cyc();
        Req1 = 1'b0;
        n_vec++;
        if ({Ack0, Ack1} !== 2'b10 || RData !== 32'hA000_0004) begin
            n_fail++;
            $display("FAIL wd_ack0: got Ack0,Ack1=%b RData=%h want 10 a0000004", {Ack0, Ack1}, RData);
        end
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if ({Ack1, Busy} !== 2'b00) begin
                n_fail++;
                $display("FAIL wd_noack1 cycle %0d: got Ack1,Busy=%b want 00", i, {Ack1, Busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_out_of_range();
        test_latch();
        test_reset_abort();
        test_withdraw();
        n_vec++;
        if (both_count !== 0) begin
            n_fail++;
            $display("FAIL mem_exclusive: got %0d cycles with write and read both high want 0", both_count);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of every data bus.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width of every address bus.
REQ-003 SHALL have parameter DEPTH, default 32, number of implemented memory words.
REQ-004 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port Reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports Req0/Req1  input  1  access request, port 0 / port 1.
REQ-007 SHALL have ports We0/We1  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports Addr0/Addr1  input  ADDR_WIDTH  word address.
REQ-009 SHALL have ports WData0/WData1  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports Ack0/Ack1  output  1  one-cycle completion pulse.
REQ-011 SHALL have ports Err0/Err1  output  1  out-of-range flag, valid with Ack.
REQ-012 SHALL have port RData  output  DATA_WIDTH  read data, valid while Ack0 or Ack1.
REQ-013 SHALL have port Busy  output  1  high whenever state is not IDLE.
REQ-014 SHALL have ports MemAddr  output  ADDR_WIDTH, MemWData  output  DATA_WIDTH, MemWrite  output  1, MemRead  output  1, driving the data memory.
REQ-015 SHALL have port MemRData  input  DATA_WIDTH  combinational read data from memory.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE; IDLE->ACCESS on any Req; ACCESS->DONE always; DONE->IDLE always.
REQ-017 SHALL sample Req0/Req1 only in IDLE; requests present in ACCESS or DONE wait.
REQ-018 SHALL arbitrate round-robin: single requester wins; both requesting -> port not granted last wins; last-grant pointer updates on each grant.
REQ-019 SHALL latch the winner's We, Addr, WData and port id on the IDLE->ACCESS edge; later changes to that port's inputs SHALL NOT affect the transaction.
REQ-020 SHALL drive MemAddr/MemWData/MemWrite/MemRead from registers; MemWrite or MemRead (per latched We) high for exactly the ACCESS cycle, both 0 otherwise.
REQ-021 SHALL never assert MemWrite and MemRead together.
REQ-022 SHALL register MemRData into RData on the ACCESS->DONE edge for reads; RData SHALL be 0 for writes and errors.
REQ-023 SHALL assert Ack of the granted port for exactly the DONE cycle; other Ack stays 0.
REQ-024 Latency: Req high in IDLE cycle N -> Ack in cycle N+2; max throughput one access per 3 cycles.
REQ-025 Out-of-range (latched Addr >= DEPTH): MemWrite/MemRead SHALL stay 0, Err of granted port high with its Ack, RData 0.
REQ-026 Requester SHALL hold Req until Ack and drop it the cycle after; Req still high in the next IDLE cycle SHALL be treated as a new request.
REQ-027 Req withdrawn before grant SHALL be dropped silently; Req withdrawn after grant SHALL still complete with Ack.
REQ-028 Addresses SHALL pass to MemAddr unmodified (word addressing, no byte lanes).

Reset
REQ-029 Reset_n low SHALL immediately force state IDLE, last-grant pointer = port 1 (port 0 wins first tie), and Ack0/Ack1/Err0/Err1/Busy/MemWrite/MemRead = 0, RData/MemAddr/MemWData = 0.
REQ-030 Reset during ACCESS SHALL suppress the memory write (MemWrite cleared before the next rising edge); no Ack is produced for the aborted transaction.
REQ-031 After Reset_n rises, first Req SHALL be sampled at the first rising edge in IDLE.

Verification
REQ-032 Port 0 write Addr=5 WData=0xDEADBEEF, then port 0 read Addr=5 -> MemWrite 1 cycle, Ack0 at N+2; read Ack0 with RData=0xDEADBEEF, Err0=0.
REQ-033 Req0 and Req1 asserted same cycle after reset, both held -> port 0 Ack first, port 1 Ack 3 cycles later; repeat -> grants alternate 0,1,0,1.
REQ-034 Port 1 read Addr=32 (DEPTH=32) -> MemRead never asserted, Ack1=1, Err1=1, RData=0.
REQ-035 Port 0 write granted, Addr0/WData0 changed during ACCESS -> memory receives originally latched Addr and data.
REQ-036 Reset_n pulsed low during ACCESS of write Addr=3 WData=0x1 -> MemWrite drops immediately, no Ack, subsequent read Addr=3 returns prior contents.
REQ-037 Req1 pulsed one cycle while port 0 in ACCESS -> Req1 never serviced, no Ack1.
